argmax_pack_writer: RTL and testbench

- Hardware producer of the argmax result region (AUGMAX_OUT_ADDR) that the MVM+BN+Res+Argmax bench reads back.
- Consumes the FP16 MVM/BN/Res output stream in DDR surface order: channel group g outer, token t inner, one Tout-lane vector per beat.
- Keeps a running per-token max and index across all channel groups.
- On the last group, packs the final per-token argmax indices TOUT per word and emits addressed AXI write-data beats to the write master.

---
 rtl/argmax_pack_writer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_argmax_pack_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_pack_writer.sv
// Running per-token FP16 argmax across channel groups; the final group's indices
// are packed TOUT per word and emitted as addressed write-data beats.
module argmax_pack_writer #(
  parameter int TOUT      = 32,
  parameter int DAT_DW    = 16,
  parameter int MAX_TOKEN = 128,
  parameter int AXI_DW    = TOUT * DAT_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       token_num,
  input  logic [15:0]       ch_out,
  input  logic [31:0]       wr_base_addr,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AXI_DW-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AXI_DW-1:0] m_data,
  output logic [31:0]       m_addr,
  output logic              m_last
);
  localparam int LW = $clog2(TOUT);
  localparam int TW = $clog2(MAX_TOKEN);
  localparam int CW = 16 + LW;
  localparam int EW = 2 * DAT_DW;
  localparam logic [31:0] WORD_BYTES = 32'(AXI_DW / 8);
  localparam logic [DAT_DW-1:0] SIGN_BIT = {1'b1, {(DAT_DW-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] tn_last_q, ch_out_q, grp_last_q, word_last_q;
  logic [31:0] base_q;
  logic [15:0] tok_q, grp_q;

  logic [16:0] cfg_g_ceil;
  logic [15:0] cfg_grp_last, cfg_word_last;
  logic        start_acc, enable, in_hs, in_tok_last, in_final;

  // stage 1: registered input beat
  logic              s1_valid_q, s1_lastgrp_q, s1_final_q, s1_first_q;
  logic [AXI_DW-1:0] s1_data_q;
  logic [TW-1:0]     s1_tok_q;
  logic [15:0]       s1_grp_q;

  // stage 2: reduced lane winner plus RAM read data
  logic              s2_valid_q, s2_lastgrp_q, s2_final_q, s2_first_q;
  logic [DAT_DW-1:0] s2_key_q, s2_idx_q;
  logic [TW-1:0]     s2_tok_q;
  logic [EW-1:0]     ram_rd_q;

  // stage 3: last merged entry, also the forwarding source
  logic              s3_valid_q;
  logic [TW-1:0]     s3_tok_q;
  logic [DAT_DW-1:0] s3_key_q, s3_idx_q;

  logic [EW-1:0]     ram [MAX_TOKEN];

  logic [DAT_DW-1:0] lane_key [TOUT];
  logic [DAT_DW-1:0] red_key;
  logic [LW-1:0]     red_lane;

  logic              fwd_hit, take_new;
  logic [DAT_DW-1:0] old_key, old_idx, mrg_key, mrg_idx;
  logic [LW-1:0]     pack_lane;

  logic [AXI_DW-1:0] pack_q, pack_d;
  logic              emit_q, emit_d;
  logic [15:0]       word_q;

  logic              m_valid_q, m_last_q;
  logic [AXI_DW-1:0] m_data_q;
  logic [31:0]       m_addr_q;

  assign cfg_g_ceil    = ({1'b0, ch_out} + 17'(TOUT - 1)) >> LW;
  assign cfg_grp_last  = 16'(cfg_g_ceil - 17'd1);
  assign cfg_word_last = (token_num - 16'd1) >> LW;

  assign start_acc   = (state_q == S_IDLE) && start;
  // A held output word freezes the whole pipeline.
  assign enable      = !(m_valid_q && !m_ready);
  assign s_ready     = (state_q == S_RUN) && enable;
  assign in_hs       = s_valid && s_ready;
  assign in_tok_last = (tok_q == tn_last_q);
  assign in_final    = in_tok_last && (grp_q == grp_last_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (in_hs && in_final) state_d = S_DRAIN;
      S_DRAIN: if (m_valid_q && m_ready && m_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tn_last_q   <= '0;
      ch_out_q    <= '0;
      grp_last_q  <= '0;
      word_last_q <= '0;
      base_q      <= '0;
      tok_q       <= '0;
      grp_q       <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        tn_last_q   <= token_num - 16'd1;
        ch_out_q    <= ch_out;
        grp_last_q  <= cfg_grp_last;
        word_last_q <= cfg_word_last;
        base_q      <= wr_base_addr;
        tok_q       <= '0;
        grp_q       <= '0;
      end else if (in_hs) begin
        if (in_tok_last) begin
          tok_q <= '0;
          grp_q <= grp_q + 16'd1;
        end else begin
          tok_q <= tok_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_lastgrp_q <= 1'b0;
      s1_final_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_tok_q     <= '0;
      s1_grp_q     <= '0;
    end else if (enable) begin
      s1_valid_q   <= in_hs;
      s1_lastgrp_q <= (grp_q == grp_last_q);
      s1_final_q   <= in_final;
      s1_first_q   <= (grp_q == 16'd0);
      s1_data_q    <= s_data;
      s1_tok_q     <= tok_q[TW-1:0];
      s1_grp_q     <= grp_q;
    end
  end

  // Monotone unsigned key per lane; padding channels get the minimum key.
  for (genvar gi = 0; gi < TOUT; gi++) begin : g_key
    logic [DAT_DW-1:0] x;
    logic [CW-1:0]     chan;
    assign x    = s1_data_q[gi*DAT_DW +: DAT_DW];
    assign chan = {s1_grp_q, LW'(gi)};
    assign lane_key[gi] = (chan >= CW'(ch_out_q)) ? '0 :
                          (x[DAT_DW-1] ? ~x : (x | SIGN_BIT));
  end

  // Heap-ordered tournament: node n has children 2n (lower lanes) and 2n+1.
  always_comb begin : lane_tree
    logic [DAT_DW-1:0] tk [2*TOUT];
    logic [LW-1:0]     tl [2*TOUT];
    for (int n = 0; n < 2*TOUT; n++) begin
      tk[n] = '0;
      tl[n] = '0;
    end
    for (int j = 0; j < TOUT; j++) begin
      tk[TOUT+j] = lane_key[j];
      tl[TOUT+j] = LW'(j);
    end
    for (int n = TOUT - 1; n >= 1; n--) begin
      if (tk[2*n+1] > tk[2*n]) begin
        tk[n] = tk[2*n+1];
        tl[n] = tl[2*n+1];
      end else begin
        tk[n] = tk[2*n];
        tl[n] = tl[2*n];
      end
    end
    red_key  = tk[1];
    red_lane = tl[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_lastgrp_q <= 1'b0;
      s2_final_q   <= 1'b0;
      s2_first_q   <= 1'b0;
      s2_key_q     <= '0;
      s2_idx_q     <= '0;
      s2_tok_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_tok_q     <= '0;
      s3_key_q     <= '0;
      s3_idx_q     <= '0;
    end else if (enable) begin
      s2_valid_q   <= s1_valid_q;
      s2_lastgrp_q <= s1_lastgrp_q;
      s2_final_q   <= s1_final_q;
      s2_first_q   <= s1_first_q;
      s2_key_q     <= red_key;
      s2_idx_q     <= DAT_DW'({s1_grp_q, red_lane});
      s2_tok_q     <= s1_tok_q;
      s3_valid_q   <= s2_valid_q;
      s3_tok_q     <= s2_tok_q;
      s3_key_q     <= mrg_key;
      s3_idx_q     <= mrg_idx;
    end
  end

  // The RAM read issued with stage 2 misses the write landing on that same edge;
  // that write is exactly the stage-3 entry, so it is forwarded on a tok match.
  assign fwd_hit  = s3_valid_q && (s3_tok_q == s2_tok_q);
  assign old_key  = fwd_hit ? s3_key_q : ram_rd_q[EW-1:DAT_DW];
  assign old_idx  = fwd_hit ? s3_idx_q : ram_rd_q[DAT_DW-1:0];
  assign take_new = s2_first_q || (s2_key_q > old_key);
  assign mrg_key  = take_new ? s2_key_q : old_key;
  assign mrg_idx  = take_new ? s2_idx_q : old_idx;

  always_ff @(posedge clk) begin
    if (enable) begin
      if (s2_valid_q) ram[s2_tok_q] <= {mrg_key, mrg_idx};
      ram_rd_q <= ram[s1_tok_q];
    end
  end

  assign pack_lane = s2_tok_q[LW-1:0];

  always_comb begin
    pack_d = pack_q;
    emit_d = emit_q;
    if (enable) begin
      if (emit_q) begin
        pack_d = '0;
        emit_d = 1'b0;
      end
      if (s2_valid_q && s2_lastgrp_q) begin
        pack_d[pack_lane*DAT_DW +: DAT_DW] = mrg_idx;
        emit_d = (pack_lane == LW'(TOUT - 1)) || s2_final_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q    <= '0;
      emit_q    <= 1'b0;
      word_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_addr_q  <= '0;
    end else if (start_acc) begin
      pack_q <= '0;
      emit_q <= 1'b0;
      word_q <= '0;
    end else begin
      pack_q <= pack_d;
      emit_q <= emit_d;
      if (enable) begin
        if (emit_q) begin
          m_valid_q <= 1'b1;
          m_data_q  <= pack_q;
          m_addr_q  <= base_q + 32'(word_q) * WORD_BYTES;
          m_last_q  <= (word_q == word_last_q);
          word_q    <= word_q + 16'd1;
        end else if (m_ready) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_argmax_pack_writer.sv
// Directed and randomized runs of argmax_pack_writer checked against a per-token
// channel-scan argmax model.
module tb_argmax_pack_writer;
  localparam int TOUT   = 32;
  localparam int AXI_DW = 512;
  localparam int MAXT   = 128;
  localparam int MAXC   = 512;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [15:0]       token_num, ch_out;
  logic [31:0]       wr_base_addr, m_addr;
  logic              s_valid, s_ready, m_valid, m_ready, m_last;
  logic [AXI_DW-1:0] s_data, m_data;

  always #5 clk = ~clk;

  argmax_pack_writer dut (
    .clk(clk), .rst(rst), .start(start), .token_num(token_num), .ch_out(ch_out),
    .wr_base_addr(wr_base_addr), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt;
  logic [15:0]       din [MAXT][MAXC];
  logic [15:0]       exp_idx [MAXT];
  logic [AXI_DW-1:0] got_data [$];
  logic [31:0]       got_addr [$];
  logic              got_last [$];

  task automatic chk(input string tag, input logic [AXI_DW-1:0] got, input logic [AXI_DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] okey(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  // Argmax over real channels: strictly larger key wins, so the lowest channel keeps ties.
  task automatic model(input int tn, input int ch);
    for (int t = 0; t < tn; t++) begin
      int best = 0;
      for (int c = 1; c < ch; c++)
        if (okey(din[t][c]) > okey(din[t][best])) best = c;
      exp_idx[t] = 16'(best);
    end
  endtask

  task automatic fill_rand();
    for (int t = 0; t < MAXT; t++)
      for (int c = 0; c < MAXC; c++) din[t][c] = 16'($urandom);
  endtask

  task automatic check_idle(input string tag);
    chk32({tag, "_busy"}, 32'(busy), 32'd0);
    chk32({tag, "_done"}, 32'(done), 32'd0);
    chk32({tag, "_sready"}, 32'(s_ready), 32'd0);
    chk32({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    chk32({tag, "_mlast"}, 32'(m_last), 32'd0);
    chk32({tag, "_maddr"}, m_addr, 32'd0);
    chk({tag, "_mdata"}, m_data, '0);
  endtask

  task automatic load_beat(input int b, input int tn);
    int g = b / tn;
    int t = b % tn;
    for (int j = 0; j < TOUT; j++) s_data[j*16 +: 16] = din[t][g*TOUT + j];
  endtask

  task automatic drive(input int tn, input int ch, input bit gaps);
    int nb = ((ch + TOUT - 1) / TOUT) * tn;
    int b = 0;
    int cyc = 0;
    while (b < nb && cyc < 20000) begin
      @(negedge clk);
      s_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      load_beat(b, tn);
      #4;
      if (s_valid && s_ready) b++;
      cyc++;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk32("drv_beats", b, nb);
  endtask

  task automatic monitor(input bit bp, input bit glitch);
    int stall_left = 20;
    int cyc = 0;
    bit fin = 0;
    bit held = 0;
    logic [AXI_DW-1:0] pd = '0;
    logic [31:0] pa = '0;
    while (!fin && cyc < 30000) begin
      @(negedge clk);
      if (bp && m_valid && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = bp ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (glitch && cyc == 30) begin
        start = 1'b1;
        token_num = 16'd5;
      end else begin
        start = 1'b0;
      end
      #4;
      if (held) begin
        chk32("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, pd);
        chk32("hold_addr", m_addr, pa);
      end
      if (m_valid && !m_ready) chk32("hold_sready", 32'(s_ready), 32'd0);
      held = m_valid && !m_ready;
      pd = m_data;
      pa = m_addr;
      if (m_valid && m_ready) begin
        $display("word %0d addr=%h last=%0b data=%h", got_data.size(), m_addr, m_last, m_data);
        got_data.push_back(m_data);
        got_addr.push_back(m_addr);
        got_last.push_back(m_last);
      end
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      cyc++;
    end
    if (!fin) chk32("done_timeout", 32'd0, 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    #4;
    chk32("done_pulse", 32'(done), 32'd0);
    chk32("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_case(input string name, input int tn, input int ch, input logic [31:0] base,
                          input bit gaps, input bit bp, input bit glitch);
    int nw = (tn + TOUT - 1) / TOUT;
    model(tn, ch);
    got_data.delete();
    got_addr.delete();
    got_last.delete();
    done_cnt = 0;
    $display("run %s tokens=%0d ch_out=%0d", name, tn, ch);
    @(negedge clk);
    token_num = 16'(tn);
    ch_out = 16'(ch);
    wr_base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk32({name, "_busy_start"}, 32'(busy), 32'd1);
    fork
      drive(tn, ch, gaps);
      monitor(bp, glitch);
    join
    chk32({name, "_word_count"}, got_data.size(), nw);
    chk32({name, "_done_count"}, done_cnt, 32'd1);
    for (int k = 0; k < nw && k < got_data.size(); k++) begin
      logic [AXI_DW-1:0] ew = '0;
      for (int j = 0; j < TOUT; j++)
        if (k*TOUT + j < tn) ew[j*16 +: 16] = exp_idx[k*TOUT + j];
      chk({name, "_data"}, got_data[k], ew);
      chk32({name, "_addr"}, got_addr[k], base + 32'(k * 64));
      chk32({name, "_last"}, 32'(got_last[k]), 32'(k == nw - 1));
    end
  endtask

  task automatic run_reset_case();
    int b = 0;
    int cyc = 0;
    fill_rand();
    $display("run reset_mid tokens=20 ch_out=512");
    @(negedge clk);
    token_num = 16'd20;
    ch_out = 16'd512;
    wr_base_addr = 32'h2000_0000;
    start = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (b < 3*20 + 5 && cyc < 1000) begin
      s_valid = 1'b1;
      load_beat(b, 20);
      #4;
      if (s_valid && s_ready) b++;
      cyc++;
      @(negedge clk);
    end
    chk32("rst_mid_beats", b, 65);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("rst_mid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      chk32("rst_quiet_mvalid", 32'(m_valid), 32'd0);
      chk32("rst_quiet_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    token_num = '0;
    ch_out = '0;
    wr_base_addr = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // single +1.0 per token at channel (t*13)%512
    for (int t = 0; t < MAXT; t++)
      for (int c = 0; c < MAXC; c++) din[t][c] = 16'hBC00;
    for (int t = 0; t < 37; t++) din[t][(t*13) % 512] = 16'h3C00;
    run_case("basic", 37, 512, 32'h1000_0000, 1'b0, 1'b0, 1'b0);

    // ties, +0 versus -0, equal maxima in different groups
    for (int c = 0; c < MAXC; c++) begin
      din[0][c] = 16'h4000;
      din[1][c] = 16'hBC00;
      din[2][c] = 16'hBC00;
    end
    din[1][0] = 16'h8000;
    din[1][3] = 16'h0000;
    din[2][40] = 16'h3C00;
    din[2][300] = 16'h3C00;
    run_case("ties", 3, 512, 32'h1000_4000, 1'b0, 1'b0, 1'b0);

    // padding lanes hold the largest finite value
    for (int t = 0; t < MAXT; t++)
      for (int c = 0; c < MAXC; c++)
        din[t][c] = (c < 40) ? {1'($urandom), 15'($urandom_range(16'h3C00))} : 16'h7BFF;
    run_case("padding", 10, 40, 32'h1000_8000, 1'b1, 1'b0, 1'b0);

    // max grows every group: exercises back-to-back read-modify-write of one token
    for (int t = 0; t < MAXT; t++)
      for (int c = 0; c < MAXC; c++) din[t][c] = 16'h2000 + 16'(c);
    run_case("hazard1", 1, 256, 32'h1001_0000, 1'b0, 1'b0, 1'b0);
    run_case("hazard2", 2, 256, 32'h1002_0000, 1'b0, 1'b0, 1'b0);
    fill_rand();
    run_case("hazard3", 3, 100, 32'h1003_0000, 1'b0, 1'b0, 1'b0);

    fill_rand();
    run_case("backpressure", 70, 96, 32'h1004_0000, 1'b1, 1'b1, 1'b1);

    run_reset_case();
    fill_rand();
    run_case("rand_a", $urandom_range(1, 128), $urandom_range(1, 512), 32'h1005_0000, 1'b1, 1'b1, 1'b0);
    fill_rand();
    run_case("rand_b", $urandom_range(1, 128), $urandom_range(1, 512), 32'h1006_0000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
